sd_multi_block_sequencer: RTL and testbench
===========================================

SD_MULTI_BLOCK_SEQUENCER -- requirements
Module: sd_multi_block_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the block address width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the block-count width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 65535, meaning the maximum number of wait cycles per init or read phase.
REQ-004 SHALL have parameter MAX_RETRY, default 3, meaning the number of init attempts allowed after the first one.
REQ-005 SHALL use one clock and a synchronous, active-high reset: port `clock` (in, 1, the sole clock) and port `reset` (in, 1, synchronous active-high).
REQ-006 SHALL have these ports:
- `start` in 1: single-cycle request.
- `base_addr` in ADDR_W: first block address.
- `block_count` in CNT_W: number of blocks to read.
- `init_start` out 1: one-cycle pulse to the initializer.
- `init_done` in 1: initializer success.
- `init_error` in 1: initializer failure.
- `rd_start` out 1: one-cycle pulse to the block reader.
- `rd_addr` out ADDR_W: block address to read.
- `rd_busy` in 1: reader is active.
- `rd_error` in 1: reader failure.
- `fifo_full` in 1: downstream FIFO is full.
- `rd_pause` out 1: stall request to the reader.
- `busy` out 1: sequencer is not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: sticky failure flag.
- `blocks_done` out CNT_W: completed block count.
- `state_dbg` out 4: current state code.

Function
REQ-007 SHALL implement the states IDLE=0, INIT=1, WAIT_INIT=2, READ=3, WAIT_READ=4, NEXT=5, DONE=6, ERROR=7.
REQ-008 SHALL, on `start` in IDLE or ERROR, latch `base_addr` and `block_count`, clear `blocks_done`, clear `error`, and enter INIT on the next edge; if the latched count is 0, it SHALL instead enter DONE without asserting `init_start`.
REQ-009 SHALL ignore `start` in every other state.
REQ-010 SHALL assert `init_start` for exactly the one cycle spent in INIT, then enter WAIT_INIT.
REQ-011 In WAIT_INIT: `init_done` SHALL lead to READ; `init_error`, or a wait reaching TIMEOUT_CYC cycles, SHALL cause a retry or entry to ERROR (see REQ-020/021). If `init_done` and `init_error` are asserted together, `init_error` SHALL win.
REQ-012 SHALL assert `rd_start` for exactly the one cycle spent in READ, with `rd_addr` = latched base + `blocks_done`, computed modulo 2^ADDR_W (wraps silently); `rd_addr` SHALL be stable from READ through NEXT.
REQ-013 In WAIT_READ: `rd_busy` SHALL be ignored in the first cycle; afterwards, `rd_busy` low SHALL lead to NEXT; `rd_error` (priority over `rd_busy` low) or a timeout SHALL lead to ERROR with no retry.
REQ-014 SHALL drive `rd_pause` = `fifo_full` while in WAIT_READ and 0 otherwise; the timeout counter SHALL hold, not count, while `rd_pause` is 1.
REQ-015 In NEXT, SHALL increment `blocks_done`, then enter DONE if the new value equals the latched count, else enter READ.
REQ-016 In DONE, SHALL assert `done` for exactly one cycle, then return to IDLE; `blocks_done` SHALL hold its value until the next accepted `start`.
REQ-017 In ERROR, SHALL hold `error`=1 and `busy`=1 until `start` or `reset`.
REQ-018 SHALL clear the timeout counter on every state change.

Reset
REQ-019 While `reset` is high at a clock edge, SHALL force state IDLE and drive all outputs to 0 (including `blocks_done`, `rd_addr` and the retry counter), aborting any operation in progress, whether mid-init or mid-read.

Configuration
REQ-020 With SD_SEQ_RETRY_EN defined: an init failure or init timeout with retry counter < MAX_RETRY SHALL increment the counter and return to INIT; otherwise the sequencer SHALL enter ERROR. The retry counter SHALL clear on an accepted `start`.
REQ-021 Without SD_SEQ_RETRY_EN: the first init failure or init timeout SHALL enter ERROR, and no retry counter logic SHALL be present.

Structure
REQ-022 Shared package sd_pkg SHALL hold the state encoding constants and the default TIMEOUT_CYC.
REQ-023 The timeout counter SHALL be a sub-module, sd_timeout_counter, with clear, hold and expired signals.

Verification
REQ-024 base_addr=0x100, block_count=3, init_done after 5 cycles, each read busy for 10 cycles -> rd_addr sequence 0x100, 0x101, 0x102; three rd_start pulses; one done pulse; blocks_done=3.
REQ-025 block_count=0 -> DONE on the cycle after start; no init_start; done pulse.
REQ-026 With SD_SEQ_RETRY_EN and MAX_RETRY=3: init_error on every attempt -> 4 init_start pulses, then error=1. Without the macro: 1 pulse, then error=1.
REQ-027 base_addr=0xFFFFFFFF, block_count=2 -> rd_addr 0xFFFFFFFF, then 0x00000000.
REQ-028 fifo_full held for 100000 cycles in WAIT_READ with TIMEOUT_CYC=65535 -> rd_pause=1 throughout, no timeout, and completion after release.
REQ-029 reset asserted in WAIT_READ -> state_dbg=0 and all outputs 0 on the next edge; start while busy is ignored.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: state encoding, default timeout and small helpers shared by the
// SD multi-block read sequencer and its timeout counter.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_WAIT_INIT = 3'd2,
        ST_READ      = 3'd3,
        ST_WAIT_READ = 3'd4,
        ST_NEXT      = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } sd_state_e;

    localparam int SD_TIMEOUT_CYC_DEFAULT = 65535;
    localparam int SD_STATE_DBG_W         = 4;

    // Register width able to hold 0..n-1, never narrower than one bit.
    function automatic int sd_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sd_timeout_counter.sv
// sd_timeout_counter: down-counter that flags the TIMEOUT_CYC-th counted
// cycle since the last clear. Cycles with hold=1 are not counted and never
// report expiry, so a stalled reader cannot time out.
module sd_timeout_counter
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYC = SD_TIMEOUT_CYC_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic expired
);

    localparam int              TW   = sd_cnt_width(TIMEOUT_CYC);
    localparam logic [TW-1:0]   LOAD = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // Reload on clear, otherwise count down to the terminal value unless held.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD;
        end else if (!hold && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0) && !hold;

endmodule

// File: rtl/sd_multi_block_sequencer.sv
// sd_multi_block_sequencer: runs card init, then reads block_count blocks
// starting at base_addr, one rd_start per block, with per-phase timeouts.
// Optional init retry: define SD_SEQ_RETRY_EN to allow MAX_RETRY extra
// init attempts; otherwise the first init failure is final.
//
// state      | meaning
// IDLE       | waiting for start
// INIT       | one-cycle init_start pulse
// WAIT_INIT  | waiting for init_done / init_error / timeout
// READ       | one-cycle rd_start pulse, rd_addr valid
// WAIT_READ  | reader active; first cycle ignores rd_busy
// NEXT       | bump blocks_done, pick next block or finish
// DONE       | one-cycle done pulse
// ERROR      | sticky failure, left only by start or reset
module sd_multi_block_sequencer
    import sd_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = SD_TIMEOUT_CYC_DEFAULT,
    parameter int MAX_RETRY   = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [CNT_W-1:0]          block_count,
    output logic                      init_start,
    input  logic                      init_done,
    input  logic                      init_error,
    output logic                      rd_start,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic                      rd_busy,
    input  logic                      rd_error,
    input  logic                      fifo_full,
    output logic                      rd_pause,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [CNT_W-1:0]          blocks_done,
    output logic [SD_STATE_DBG_W-1:0] state_dbg
);

    sd_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   blocks_q, blocks_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               first_q;
    logic               tmo_clear;
    logic               tmo_expired;

`ifdef SD_SEQ_RETRY_EN
    localparam int RW = sd_cnt_width(MAX_RETRY + 1);
    logic [RW-1:0] retry_q, retry_d;
`endif

    assign rd_pause  = (state_q == ST_WAIT_READ) && fifo_full;
    assign tmo_clear = (state_d != state_q);

    sd_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (tmo_clear),
        .hold    (rd_pause),
        .expired (tmo_expired)
    );

    // Next-state and datapath updates; rd_addr is only recomputed on entry to READ.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        blocks_d  = blocks_q;
        rd_addr_d = rd_addr_q;
`ifdef SD_SEQ_RETRY_EN
        retry_d   = retry_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start) begin
                    base_d   = base_addr;
                    count_d  = block_count;
                    blocks_d = '0;
`ifdef SD_SEQ_RETRY_EN
                    retry_d  = '0;
`endif
                    state_d  = (block_count == '0) ? ST_DONE : ST_INIT;
                end
            end
            ST_INIT: state_d = ST_WAIT_INIT;
            ST_WAIT_INIT: begin
                if (init_error || tmo_expired) begin
`ifdef SD_SEQ_RETRY_EN
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_INIT;
                    end else begin
                        state_d = ST_ERROR;
                    end
`else
                    state_d = ST_ERROR;
`endif
                end else if (init_done) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: state_d = ST_WAIT_READ;
            ST_WAIT_READ: begin
                if (rd_error || tmo_expired) begin
                    state_d = ST_ERROR;
                end else if (!first_q && !rd_busy) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                blocks_d = blocks_q + 1'b1;
                state_d  = (blocks_d == count_q) ? ST_DONE : ST_READ;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_READ) begin
            rd_addr_d = base_d + ADDR_W'(blocks_d);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            count_q   <= '0;
            blocks_q  <= '0;
            rd_addr_q <= '0;
            first_q   <= 1'b0;
`ifdef SD_SEQ_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            count_q   <= count_d;
            blocks_q  <= blocks_d;
            rd_addr_q <= rd_addr_d;
            first_q   <= (state_q == ST_READ);
`ifdef SD_SEQ_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign init_start  = (state_q == ST_INIT);
    assign rd_start    = (state_q == ST_READ);
    assign done        = (state_q == ST_DONE);
    assign error       = (state_q == ST_ERROR);
    assign busy        = (state_q != ST_IDLE);
    assign rd_addr     = rd_addr_q;
    assign blocks_done = blocks_q;
    assign state_dbg   = SD_STATE_DBG_W'(state_q);

endmodule

// File: tb/tb_sd_multi_block_sequencer.sv
// Bench for sd_multi_block_sequencer: emulates initializer and reader,
// records pulses and addresses, and compares against expected sequences and
// cycle counts derived from the block's rules. Honors SD_SEQ_RETRY_EN.
module tb_sd_multi_block_sequencer;

    localparam int AW  = 32;
    localparam int CW  = 16;
    localparam int TMO = 64;
    localparam int MR  = 3;
`ifdef SD_SEQ_RETRY_EN
    localparam int ATTEMPTS = MR + 1;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] block_count = '0;
    logic          init_start;
    logic          init_done = 1'b0;
    logic          init_error = 1'b0;
    logic          rd_start;
    logic [AW-1:0] rd_addr;
    logic          rd_busy = 1'b0;
    logic          rd_error = 1'b0;
    logic          fifo_full = 1'b0;
    logic          rd_pause;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] blocks_done;
    logic [3:0]    state_dbg;

    sd_multi_block_sequencer #(
        .ADDR_W(AW), .CNT_W(CW), .TIMEOUT_CYC(TMO), .MAX_RETRY(MR)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .block_count(block_count), .init_start(init_start), .init_done(init_done),
        .init_error(init_error), .rd_start(rd_start), .rd_addr(rd_addr),
        .rd_busy(rd_busy), .rd_error(rd_error), .fifo_full(fifo_full),
        .rd_pause(rd_pause), .busy(busy), .done(done), .error(error),
        .blocks_done(blocks_done), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // responder configuration: init_mode 0=done, 1=error, 2=silent
    int init_mode = 0;
    int init_delay = 5;
    int init_cd = 0;
    int rd_lo = 10;
    int rd_hi = 10;
    int rd_cd = 0;
    bit fifo_rand = 1'b0;

    logic [AW-1:0] addr_q[$];
    int            lat_q[$];
    int            n_init = 0;
    int            n_done = 0;

    // Initializer / reader emulation, acting 2 time units after each rising edge.
    always @(posedge clock) begin
        #2;
        init_done  = 1'b0;
        init_error = 1'b0;
        if (reset) begin
            init_cd = 0;
            rd_cd   = 0;
            rd_busy = 1'b0;
        end else begin
            if (init_start) begin
                init_cd = init_delay;
            end else if (init_cd > 0) begin
                init_cd--;
                if (init_cd == 0) begin
                    if (init_mode == 0) init_done = 1'b1;
                    else if (init_mode == 1) init_error = 1'b1;
                end
            end
            if (rd_start) begin
                rd_cd   = $urandom_range(rd_hi, rd_lo);
                lat_q.push_back(rd_cd);
                rd_busy = 1'b1;
            end else if (rd_cd > 0) begin
                rd_cd--;
                if (rd_cd == 0) rd_busy = 1'b0;
            end
            if (fifo_rand) fifo_full = ($urandom_range(3, 0) == 0);
        end
    end

    // Pulse and address recorder.
    always @(negedge clock) begin
        if (!reset) begin
            if (rd_start)   addr_q.push_back(rd_addr);
            if (init_start) n_init++;
            if (done)       n_done++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic start_xfer(input logic [AW-1:0] base, input logic [CW-1:0] cnt);
        addr_q.delete();
        lat_q.delete();
        n_init = 0;
        n_done = 0;
        base_addr   = base;
        block_count = cnt;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (done || error) begin
                to = 1'b0;
                break;
            end
            step();
            cyc++;
        end
    endtask

    task automatic wait_state(input string tag, input logic [3:0] st, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (state_dbg == st) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk(tag, seen, 1'b1);
    endtask

    task automatic check_addrs(input string tag, input logic [AW-1:0] base, input int cnt);
        int bad;
        logic [AW-1:0] exp;
        bad = 0;
        chk({tag, "_addr_count"}, addr_q.size(), cnt);
        for (int k = 0; k < cnt; k++) begin
            exp = base + AW'(k);
            if (k >= addr_q.size() || addr_q[k] !== exp) bad++;
        end
        chk({tag, "_addr_seq_bad"}, bad, 0);
    endtask

    task automatic run_good(input string tag, input logic [AW-1:0] base, input int cnt,
                            input int d, input bit poke);
        int cyc;
        bit to;
        int exp_cyc;
        init_mode  = 0;
        init_delay = d;
        start_xfer(base, cnt[CW-1:0]);
        if (poke) begin
            step();
            start = 1'b1;
            base_addr = ~base;
            block_count = cnt[CW-1:0] + 16'd3;
            step();
            start = 1'b0;
        end
        wait_end(5000, cyc, to);
        if (poke) cyc += 2;
        chk({tag, "_no_hang"}, to, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
        chk({tag, "_read_count"}, lat_q.size(), cnt);
        exp_cyc = 1 + d;
        foreach (lat_q[k]) exp_cyc += lat_q[k] + 2;
        chk({tag, "_done_cycle"}, cyc, exp_cyc);
        step();
        chk({tag, "_blocks_done"}, blocks_done, cnt);
        chk({tag, "_done_pulses"}, n_done, 1);
        chk({tag, "_init_pulses"}, n_init, 1);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        check_addrs(tag, base, cnt);
    endtask

    initial begin
        int cyc;
        bit to;
        int bad;
        logic [AW-1:0] rb;

        do_reset();
        chk("rst_state", state_dbg, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_blocks", blocks_done, '0);
        chk("rst_rd_addr", rd_addr, '0);
        chk("rst_pulses", {init_start, rd_start, rd_pause}, 3'b000);

        // three blocks from 0x100, init after 5, reads 10 cycles, start poked while busy
        rd_lo = 10; rd_hi = 10;
        run_good("basic", 32'h100, 3, 5, 1'b1);

        // zero-length request
        start_xfer(32'hABC, '0);
        chk("zero_state", state_dbg, 4'd6);
        chk("zero_done", done, 1'b1);
        step();
        chk("zero_idle", state_dbg, 4'd0);
        chk("zero_init_pulses", n_init, 0);
        chk("zero_done_pulses", n_done, 1);
        chk("zero_blocks", blocks_done, '0);

        // address wrap
        rd_lo = 2; rd_hi = 6;
        run_good("wrap", 32'hFFFF_FFFF, 2, 3, 1'b0);

        // init failure every attempt
        init_mode = 1; init_delay = 2;
        start_xfer(32'h40, 16'd2);
        wait_end(2000, cyc, to);
        chk("initerr_no_hang", to, 1'b0);
        chk("initerr_cycle", cyc, ATTEMPTS * 3);
        step(); step(); step();
        chk("initerr_pulses", n_init, ATTEMPTS);
        chk("initerr_sticky", {error, busy, state_dbg}, {2'b11, 4'd7});
        chk("initerr_no_reads", addr_q.size(), 0);

        // init timeout, restarted from ERROR
        init_mode = 2;
        start_xfer(32'h80, 16'd1);
        chk("restart_error_clear", error, 1'b0);
        wait_end(2000, cyc, to);
        chk("inittmo_no_hang", to, 1'b0);
        chk("inittmo_cycle", cyc, ATTEMPTS * (TMO + 1));
        step();
        chk("inittmo_pulses", n_init, ATTEMPTS);
        chk("inittmo_error", error, 1'b1);

        // recovery from ERROR with a normal transfer
        run_good("recover", 32'h2000, 2, 4, 1'b0);

        // read timeout without pause
        rd_lo = 100; rd_hi = 100;
        init_mode = 0; init_delay = 3;
        start_xfer(32'h300, 16'd2);
        wait_end(2000, cyc, to);
        chk("rdtmo_no_hang", to, 1'b0);
        chk("rdtmo_cycle", cyc, 1 + 3 + 1 + TMO);
        chk("rdtmo_error", error, 1'b1);
        chk("rdtmo_blocks", blocks_done, '0);

        // long fifo stall holds the timeout
        rd_lo = 250; rd_hi = 250;
        start_xfer(32'h500, 16'd1);
        wait_state("pause_reach_wait_read", 4'd4, 50);
        fifo_full = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (rd_pause !== 1'b1 || state_dbg !== 4'd4) bad++;
        end
        chk("pause_held_bad", bad, 0);
        fifo_full = 1'b0;
        step();
        chk("pause_released", rd_pause, 1'b0);
        wait_end(500, cyc, to);
        chk("pause_no_hang", to, 1'b0);
        chk("pause_done", {done, error}, 2'b10);
        step();
        chk("pause_blocks", blocks_done, 16'd1);

        // reader error
        rd_lo = 20; rd_hi = 20;
        start_xfer(32'h600, 16'd3);
        wait_state("rderr_reach_wait_read", 4'd4, 50);
        step(); step();
        rd_error = 1'b1;
        step();
        rd_error = 1'b0;
        chk("rderr_state", {error, state_dbg}, {1'b1, 4'd7});

        // reset mid-read aborts
        start_xfer(32'h700, 16'd3);
        wait_state("rst_reach_wait_read", 4'd4, 50);
        step();
        fifo_full = 1'b1;
        reset = 1'b1;
        step();
        chk("midrst_state", state_dbg, 4'd0);
        chk("midrst_outs", {busy, done, error, init_start, rd_start, rd_pause}, 6'b0);
        chk("midrst_addr_blocks", {rd_addr, blocks_done}, 48'h0);
        reset = 1'b0;
        fifo_full = 1'b0;
        step();

        // randomized transfers
        rd_lo = 2; rd_hi = 12;
        fifo_rand = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) rb = $urandom;
            else rb = 32'hFFFF_FFFF - AW'($urandom_range(3, 0));
            run_good("rand", rb, $urandom_range(5, 1), $urandom_range(10, 1), i == 3);
        end
        fifo_rand = 1'b0;
        fifo_full = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
